rot_word_serializer: RTL and testbench



---
 rtl/rot_ser_pkg.sv | 28 ++
 rtl/rot_ser_bit_tick.sv | 44 ++++
 rtl/rot_word_serializer.sv | 135 +++++++++++++
 tb/tb_rot_word_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rot_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rot_ser_pkg
// Description : Shared state encoding, line levels and frame-length helper
//               for the rot_word_serializer block.
// Revision    : 1.0 - initial release
// ============================================================================
package rot_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Total serial frame duration in clock cycles.
    function automatic int frame_len(input int width, input int div,
                                     input int stop_bits, input int p);
        return (1 + width + p + stop_bits) * div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rot_ser_bit_tick.sv
`default_nettype none
// ============================================================================
// Module      : rot_ser_bit_tick
// Description : Bit-period divider counting 0..DIV-1; tick_o marks the last
//               cycle of each serial bit. clr_i holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_ser_bit_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rot_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rot_word_serializer
// Description : Parallel-to-serial framer (start, MSB-first data, optional
//               even parity under ROT_SER_PARITY_EN, stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
module rot_word_serializer
    import rot_ser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 4,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   STOP_LAST = CW'(STOP_BITS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             frame_done_q, frame_done_d;
    logic             tick;
`ifdef ROT_SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    rot_ser_bit_tick #(
        .DIV    (DIV)
    ) u_bit_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;
`ifdef ROT_SER_PARITY_EN
        parity_d     = parity_q;
`endif
        in_ready     = (state_q == IDLE);
        busy         = (state_q != IDLE);
        ser_out      = LINE_IDLE;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
`ifdef ROT_SER_PARITY_EN
                    parity_d = ^in_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                ser_out = LINE_START;
                if (tick) state_d = DATA;
            end
            DATA: begin
                ser_out = shreg_q[WIDTH-1];
                if (tick) begin
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef ROT_SER_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
`ifdef ROT_SER_PARITY_EN
            PARITY: begin
                ser_out = parity_q;
                if (tick) state_d = STOP;
            end
`endif
            // The bit counter is reused to count stop bits.
            STOP: begin
                ser_out = LINE_IDLE;
                if (tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d    = '0;
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            frame_done_q <= 1'b0;
`ifdef ROT_SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            frame_done_q <= frame_done_d;
`ifdef ROT_SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rot_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_word_serializer
// Description : Self-checking bench for rot_word_serializer (two configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_word_serializer;
    import rot_ser_pkg::*;

    localparam int DIV_A  = 2;
    localparam int STOP_A = 1;
    localparam int DIV_B  = 1;
    localparam int STOP_B = 2;
`ifdef ROT_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct packed {
        logic ser;
        logic rdy;
        logic done;
    } exp_t;

    typedef struct {
        logic [3:0] data;
        logic       par;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       ser_a, ser_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rot_word_serializer #(
        .WIDTH      (4),
        .DIV        (DIV_A),
        .STOP_BITS  (STOP_A)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data_a),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .ser_out    (ser_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    rot_word_serializer #(
        .WIDTH      (4),
        .DIV        (DIV_B),
        .STOP_BITS  (STOP_B)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .ser_out    (ser_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int which, input exp_t e);
        if (which == 0) qa.push_back(e);
        else            qb.push_back(e);
    endtask

    // Reference frame: one entry per clock cycle after acceptance, ending
    // with the idle cycle that carries the frame_done pulse.
    task automatic push_frame(input int which, input logic [3:0] d, input logic par);
        int   div;
        int   stops;
        logic bitv;
        div   = (which == 0) ? DIV_A  : DIV_B;
        stops = (which == 0) ? STOP_A : STOP_B;
        for (int k = 0; k < 1 + 4 + P + stops; k++) begin
            if (k == 0)                  bitv = 1'b0;
            else if (k <= 4)             bitv = d[4-k];
            else if (P == 1 && k == 5)   bitv = par;
            else                         bitv = 1'b1;
            for (int r = 0; r < div; r++)
                push_exp(which, '{ser: bitv, rdy: 1'b0, done: 1'b0});
        end
        push_exp(which, '{ser: 1'b1, rdy: 1'b1, done: 1'b1});
    endtask

    // Offers a word in an idle cycle; returns one cycle after acceptance.
    task automatic accept(input int which, input logic [3:0] d, input logic par);
        if (which == 0) begin in_valid_a = 1'b1; in_data_a = d; end
        else            begin in_valid_b = 1'b1; in_data_b = d; end
        @(posedge clk); #1;
        push_frame(which, d, par);
        if (which == 0) in_valid_a = 1'b0;
        else            in_valid_b = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && qa.size() > 0) begin
            e = qa.pop_front();
            check("a_ser_out",    ser_a,      e.ser);
            check("a_in_ready",   in_ready_a, e.rdy);
            check("a_busy",       busy_a,     ~e.rdy);
            check("a_frame_done", done_a,     e.done);
        end
        if (rst_n && qb.size() > 0) begin
            e = qb.pop_front();
            check("b_ser_out",    ser_b,      e.ser);
            check("b_in_ready",   in_ready_b, e.rdy);
            check("b_busy",       busy_b,     ~e.rdy);
            check("b_frame_done", done_b,     e.done);
        end
    end

    initial begin
        vec_t vecs[6];
        int   la;
        int   lb;
        vecs[0] = '{data: 4'b1011, par: 1'b1};
        vecs[1] = '{data: 4'b1001, par: 1'b0};
        vecs[2] = '{data: 4'b0000, par: 1'b0};
        vecs[3] = '{data: 4'b1111, par: 1'b0};
        vecs[4] = '{data: 4'b0111, par: 1'b1};
        vecs[5] = '{data: 4'b1000, par: 1'b1};
        la = frame_len(4, DIV_A, STOP_A, P);
        lb = frame_len(4, DIV_B, STOP_B, P);

        rst_n      = 1'b0;
        in_data_a  = 4'h0;
        in_data_b  = 4'h0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        #2;
        check("rst_ser_out",    ser_a,      1'b1);
        check("rst_in_ready",   in_ready_a, 1'b1);
        check("rst_busy",       busy_a,     1'b0);
        check("rst_frame_done", done_a,     1'b0);
        check("rst_b_ser_out",  ser_b,      1'b1);
        check("rst_b_busy",     busy_b,     1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            accept(0, vecs[i].data, vecs[i].par);
            repeat (la + 1) @(posedge clk);
            #1;
        end

        // Back-to-back with in_valid held: 4'h5 must go in the done cycle.
        in_valid_a = 1'b1;
        in_data_a  = 4'hA;
        @(posedge clk); #1;
        push_frame(0, 4'hA, 1'b0);
        repeat (la) @(posedge clk);
        #1 in_data_a = 4'h5;
        @(posedge clk); #1;
        push_frame(0, 4'h5, 1'b0);
        in_valid_a = 1'b0;
        repeat (la + 1) @(posedge clk);
        #1;

        // Input churn during a frame must not leak into it.
        accept(0, 4'b1100, 1'b0);
        for (int c = 1; c < la; c++) begin
            in_data_a  = 4'($urandom);
            in_valid_a = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        in_data_a  = 4'($urandom);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset during the second data bit.
        accept(0, 4'b0101, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ser_out",    ser_a,      1'b1);
        check("midrst_busy",       busy_a,     1'b0);
        check("midrst_in_ready",   in_ready_a, 1'b1);
        check("midrst_frame_done", done_a,     1'b0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        accept(0, 4'b1011, 1'b1);
        repeat (la + 1) @(posedge clk);
        #1;

        // Single-cycle bits, two stop bits.
        accept(1, 4'b0110, 1'b0);
        repeat (lb + 1) @(posedge clk);
        #1;
        accept(1, 4'b1011, 1'b1);
        repeat (lb + 1) @(posedge clk);
        #1;

        check_int("a_queue_drained", qa.size(), 0);
        check_int("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
